// File: rtl/ulpb_tx_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ulpb_tx_sched_pkg
// Brief   : Shared widths and FSM state encodings for the ULPB TX scheduler.
// Revision: 1.0
// ============================================================================
package ulpb_tx_sched_pkg;

    localparam int ULPB_ADDR_WIDTH = 8;
    localparam int ULPB_DATA_WIDTH = 32;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_REQ   = 3'd1;
    localparam state_t ST_ACKLO = 3'd2;
    localparam state_t ST_NEXT  = 3'd3;
    localparam state_t ST_RESP  = 3'd4;
    localparam state_t ST_RACK  = 3'd5;

endpackage
`default_nettype wire

// File: rtl/ulpb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : ulpb_rr_pick
// Brief   : Combinational round-robin pick: first request at or after ptr.
// Revision: 1.0
// ============================================================================
module ulpb_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               found
);

    always_comb begin
        int idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ulpb_tx_sched.sv
`default_nettype none
// ============================================================================
// Module  : ulpb_tx_sched
// Brief   : Two-tier round-robin scheduler sharing the ULPB node TX port.
// Revision: 1.0
// ============================================================================
module ulpb_tx_sched
    import ulpb_tx_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = ULPB_ADDR_WIDTH,
    parameter int DATA_WIDTH = ULPB_DATA_WIDTH
) (
    input  logic                          CLK_EXT,
    input  logic                          RESETn,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]            REQ_PEND,
    input  logic [NUM_REQ-1:0]            REQ_PRIO,
    output logic [NUM_REQ-1:0]            REQ_ACK,
    output logic [NUM_REQ-1:0]            REQ_DONE,
    output logic                          REQ_STATUS,
    output logic [ADDR_WIDTH-1:0]         TX_ADDR,
    output logic [DATA_WIDTH-1:0]         TX_DATA,
    output logic                          TX_PEND,
    output logic                          TX_REQ,
    output logic                          PRIORITY,
    input  logic                          TX_ACK,
    input  logic                          TX_SUCC,
    input  logic                          TX_FAIL,
    output logic                          TX_RESP_ACK,
    output logic                          BUSY
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic ack_meta, ack_sync;
    logic succ_meta, succ_sync;
    logic fail_meta, fail_sync;

    state_t state, state_nxt;

    logic [PTR_W-1:0]   grant;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_next;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;

    logic [PTR_W-1:0]      sel_idx;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_pend;
    logic                  sel_prio;

    always_ff @(posedge CLK_EXT or negedge RESETn) begin
        if (!RESETn) begin
            ack_meta  <= 1'b0;
            ack_sync  <= 1'b0;
            succ_meta <= 1'b0;
            succ_sync <= 1'b0;
            fail_meta <= 1'b0;
            fail_sync <= 1'b0;
        end else begin
            ack_meta  <= TX_ACK;
            ack_sync  <= ack_meta;
            succ_meta <= TX_SUCC;
            succ_sync <= succ_meta;
            fail_meta <= TX_FAIL;
            fail_sync <= fail_meta;
        end
    end

    // Priority requesters form the candidate set whenever any of them is valid.
    assign cand = (|(REQ_VALID & REQ_PRIO)) ? (REQ_VALID & REQ_PRIO) : REQ_VALID;

    ulpb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req   (cand),
        .ptr   (rr_ptr),
        .grant (pick_oh),
        .found (pick_found)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
    end

    assign rr_next  = (grant == PTR_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    assign sel_idx  = (state == ST_IDLE) ? pick_idx : grant;
    assign sel_addr = REQ_ADDR[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_data = REQ_DATA[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_pend = REQ_PEND[sel_idx];
    assign sel_prio = REQ_PRIO[sel_idx];

    always_ff @(posedge CLK_EXT or negedge RESETn) begin
        if (!RESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // TX_FAIL outranks TX_ACK in every in-flight state: the node lost or aborted.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (pick_found) state_nxt = ST_REQ;
            ST_REQ: begin
                if (fail_sync)     state_nxt = ST_RACK;
                else if (ack_sync) state_nxt = ST_ACKLO;
            end
            ST_ACKLO: begin
                if (fail_sync)      state_nxt = ST_RACK;
                else if (!ack_sync) state_nxt = TX_PEND ? ST_NEXT : ST_RESP;
            end
            ST_NEXT: begin
                if (fail_sync)             state_nxt = ST_RACK;
                else if (REQ_VALID[grant]) state_nxt = ST_REQ;
            end
            ST_RESP:  if (succ_sync || fail_sync) state_nxt = ST_RACK;
            ST_RACK:  if (!succ_sync && !fail_sync) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        TX_REQ      = 1'b0;
        TX_RESP_ACK = 1'b0;
        BUSY        = 1'b0;
        case (state)
            ST_REQ:  TX_REQ      = 1'b1;
            ST_RACK: TX_RESP_ACK = 1'b1;
            default: ;
        endcase
        BUSY = (state != ST_IDLE);
    end

    always_ff @(posedge CLK_EXT or negedge RESETn) begin
        if (!RESETn) begin
            grant      <= '0;
            rr_ptr     <= '0;
            TX_ADDR    <= '0;
            TX_DATA    <= '0;
            TX_PEND    <= 1'b0;
            PRIORITY   <= 1'b0;
            REQ_ACK    <= '0;
            REQ_DONE   <= '0;
            REQ_STATUS <= 1'b0;
        end else begin
            REQ_ACK    <= '0;
            REQ_DONE   <= '0;
            REQ_STATUS <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant    <= pick_idx;
                        TX_ADDR  <= sel_addr;
                        TX_DATA  <= sel_data;
                        TX_PEND  <= sel_pend;
                        PRIORITY <= sel_prio;
                    end
                end
                ST_REQ: begin
                    if (fail_sync)     REQ_DONE[grant] <= 1'b1;
                    else if (ack_sync) REQ_ACK[grant]  <= 1'b1;
                end
                ST_ACKLO: begin
                    if (fail_sync) REQ_DONE[grant] <= 1'b1;
                end
                ST_NEXT: begin
                    if (fail_sync) begin
                        REQ_DONE[grant] <= 1'b1;
                    end else if (REQ_VALID[grant]) begin
                        TX_ADDR <= sel_addr;
                        TX_DATA <= sel_data;
                        TX_PEND <= sel_pend;
                    end
                end
                ST_RESP: begin
                    if (succ_sync || fail_sync) begin
                        REQ_DONE[grant] <= 1'b1;
                        REQ_STATUS      <= succ_sync;
                    end
                end
                ST_RACK: begin
                    // Pointer moves only once a message is fully closed out.
                    if (!succ_sync && !fail_sync) rr_ptr <= rr_next;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ulpb_tx_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_ulpb_tx_sched
// Brief   : Scoreboard bench for ulpb_tx_sched with a node model and requesters.
// Revision: 1.0
// ============================================================================
module tb_ulpb_tx_sched;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid, req_pend, req_prio, req_ack, req_done;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic            req_status, tx_pend, tx_req, tx_priority, tx_resp_ack, busy;
    logic            tx_ack, tx_succ, tx_fail;
    logic [AW-1:0]   tx_addr;
    logic [DW-1:0]   tx_data;

    ulpb_tx_sched #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .CLK_EXT     (clk),
        .RESETn      (rstn),
        .REQ_VALID   (req_valid),
        .REQ_ADDR    (req_addr),
        .REQ_DATA    (req_data),
        .REQ_PEND    (req_pend),
        .REQ_PRIO    (req_prio),
        .REQ_ACK     (req_ack),
        .REQ_DONE    (req_done),
        .REQ_STATUS  (req_status),
        .TX_ADDR     (tx_addr),
        .TX_DATA     (tx_data),
        .TX_PEND     (tx_pend),
        .TX_REQ      (tx_req),
        .PRIORITY    (tx_priority),
        .TX_ACK      (tx_ack),
        .TX_SUCC     (tx_succ),
        .TX_FAIL     (tx_fail),
        .TX_RESP_ACK (tx_resp_ack),
        .BUSY        (busy)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          pend;
        logic          prio;
    } word_t;

    typedef struct packed {
        logic [N-1:0] vec;
        logic         st;
    } done_t;

    word_t        exp_words[$];
    logic [N-1:0] exp_acks[$];
    done_t        exp_dones[$];
    int total = 0;
    int bad   = 0;

    // Requester agents: each holds a short word list, advanced on REQ_ACK.
    logic [AW-1:0] rm_addr [N][4];
    logic [DW-1:0] rm_data [N][4];
    logic          rm_pend [N][4];
    logic [N-1:0]  rprio = '0;
    int rlen  [N] = '{default: 0};
    int rgen  [N] = '{default: 0};
    int rseen [N] = '{default: 0};
    int rhead [N] = '{default: 0};

    initial forever begin
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (rseen[i] != rgen[i]) begin
                rseen[i] <= rgen[i];
                rhead[i] <= 0;
            end else if (req_done[i] && !req_status) begin
                rhead[i] <= rlen[i];
            end else if (req_ack[i] && rhead[i] < rlen[i]) begin
                rhead[i] <= rhead[i] + 1;
            end
        end
    end

    always_comb begin
        req_valid = '0;
        req_pend  = '0;
        req_addr  = '0;
        req_data  = '0;
        req_prio  = rprio;
        for (int i = 0; i < N; i++) begin
            if (rseen[i] == rgen[i] && rhead[i] < rlen[i] && rhead[i] < 4) begin
                req_valid[i]         = 1'b1;
                req_addr[i*AW +: AW] = rm_addr[i][rhead[i]];
                req_data[i*DW +: DW] = rm_data[i][rhead[i]];
                req_pend[i]          = rm_pend[i][rhead[i]];
            end
        end
    end

    // Node model: acks each word, then answers with SUCC or FAIL.
    localparam int N_IDLE = 0, N_ACKW = 1, N_ACKH = 2, N_RESPW = 3;
    localparam int N_RESPH = 4, N_RELW = 5, N_FAIL = 6;
    int nst = N_IDLE;
    int ncnt = 0;
    int nword = 0;
    int fail_word = 0;
    logic hold_resp = 1'b0;

    initial begin
        tx_ack  = 1'b0;
        tx_succ = 1'b0;
        tx_fail = 1'b0;
    end

    initial forever begin
        @(posedge clk);
        if (!rstn) begin
            nst     <= N_IDLE;
            ncnt    <= 0;
            nword   <= 0;
            tx_ack  <= 1'b0;
            tx_succ <= 1'b0;
            tx_fail <= 1'b0;
        end else begin
            case (nst)
                N_IDLE: if (tx_req) begin
                    nword <= nword + 1;
                    ncnt  <= 0;
                    nst   <= (nword + 1 == fail_word) ? N_FAIL : N_ACKW;
                end
                N_ACKW: if (ncnt == 2) begin
                    tx_ack <= 1'b1;
                    nst    <= N_ACKH;
                end else ncnt <= ncnt + 1;
                N_ACKH: if (!tx_req) begin
                    tx_ack <= 1'b0;
                    ncnt   <= 0;
                    nst    <= tx_pend ? N_IDLE : N_RESPW;
                end
                N_RESPW: if (ncnt == 2 && !hold_resp) begin
                    tx_succ <= 1'b1;
                    nst     <= N_RESPH;
                end else if (ncnt < 2) ncnt <= ncnt + 1;
                N_FAIL: if (ncnt == 1) begin
                    tx_fail <= 1'b1;
                    nst     <= N_RESPH;
                end else ncnt <= ncnt + 1;
                N_RESPH: if (tx_resp_ack) begin
                    tx_succ <= 1'b0;
                    tx_fail <= 1'b0;
                    nst     <= N_RELW;
                end
                N_RELW: if (!tx_resp_ack) begin
                    nword <= 0;
                    nst   <= N_IDLE;
                end
                default: nst <= N_IDLE;
            endcase
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a bus word, ack or done.
    logic prev_txreq = 1'b0;
    logic prev_rack  = 1'b0;
    initial forever begin
        word_t w, e;
        logic [N-1:0] ea;
        done_t d, ed;
        @(negedge clk);
        if (tx_req && !prev_txreq) begin
            w = '{addr: tx_addr, data: tx_data, pend: tx_pend, prio: tx_priority};
            total++;
            if (exp_words.size() == 0) begin
                bad++;
                $display("FAIL bus_word: got %h required none", w);
            end else begin
                e = exp_words.pop_front();
                if (w !== e) begin
                    bad++;
                    $display("FAIL bus_word: got %h required %h", w, e);
                end
            end
        end
        if (req_ack != '0) begin
            total++;
            if (exp_acks.size() == 0) begin
                bad++;
                $display("FAIL req_ack: got %b required none", req_ack);
            end else begin
                ea = exp_acks.pop_front();
                if (req_ack !== ea) begin
                    bad++;
                    $display("FAIL req_ack: got %b required %b", req_ack, ea);
                end
            end
        end
        if (req_done != '0) begin
            d = '{vec: req_done, st: req_status};
            total++;
            if (exp_dones.size() == 0) begin
                bad++;
                $display("FAIL req_done: got %b/%b required none", d.vec, d.st);
            end else begin
                ed = exp_dones.pop_front();
                if (d !== ed) begin
                    bad++;
                    $display("FAIL req_done: got %b/%b required %b/%b", d.vec, d.st, ed.vec, ed.st);
                end
            end
        end
        if (prev_rack && !tx_resp_ack && rstn) begin
            total++;
            if (tx_succ || tx_fail) begin
                bad++;
                $display("FAIL resp_ack_release: succ=%b fail=%b required 0/0", tx_succ, tx_fail);
            end
        end
        prev_txreq = tx_req;
        prev_rack  = tx_resp_ack;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic set_word(input int r, input int k, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic p);
        rm_addr[r][k] = a;
        rm_data[r][k] = d;
        rm_pend[r][k] = p;
    endtask

    task automatic start_req(input int r, input int n, input logic p);
        rprio[r] = p;
        rlen[r]  = n;
        rgen[r]  = rgen[r] + 1;
    endtask

    task automatic exp_word(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic p, input logic pr);
        exp_words.push_back('{addr: a, data: d, pend: p, prio: pr});
    endtask

    task automatic exp_ack(input int r);
        exp_acks.push_back(N'(1) << r);
    endtask

    task automatic exp_done(input int r, input logic st);
        exp_dones.push_back('{vec: N'(1) << r, st: st});
    endtask

    // Single-word message with its ack and successful completion.
    task automatic one_msg(input int r, input logic [AW-1:0] a, input logic pr);
        exp_word(a, {24'h0, a}, 1'b0, pr);
        exp_ack(r);
        exp_done(r, 1'b1);
    endtask

    task automatic wait_quiet(input string nm);
        int n = 0;
        int q = 0;
        logic drained;
        while (q < 6 && n < 3000) begin
            @(negedge clk);
            n++;
            drained = 1'b1;
            for (int i = 0; i < N; i++)
                if (rseen[i] != rgen[i] || rhead[i] < rlen[i]) drained = 1'b0;
            if (!busy && drained) q++;
            else q = 0;
        end
        total++;
        if (q < 6) begin
            bad++;
            $display("FAIL %s: timeout busy=%b required 0", nm, busy);
        end
    endtask

    function automatic logic [63:0] out_bundle();
        return 64'({tx_req, tx_resp_ack, busy, req_ack, req_done, req_status,
                    tx_addr, tx_data, tx_pend, tx_priority});
    endfunction

    initial begin
        repeat (40000) @(posedge clk);
        bad++;
        total++;
        $display("FAIL watchdog: run exceeded cycle budget");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset_outputs", out_bundle(), 64'h0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Single word from requester 1; pointer then sits at 2.
        set_word(1, 0, 8'h05, 32'h0000_0005, 1'b0);
        one_msg(1, 8'h05, 1'b0);
        start_req(1, 1, 1'b0);
        wait_quiet("single_word");

        // Pointer at 2: requester 3 beats requester 0.
        set_word(0, 0, 8'h06, 32'h0000_0006, 1'b0);
        set_word(3, 0, 8'h07, 32'h0000_0007, 1'b0);
        one_msg(3, 8'h07, 1'b0);
        one_msg(0, 8'h06, 1'b0);
        start_req(0, 1, 1'b0);
        start_req(3, 1, 1'b0);
        wait_quiet("pointer_after_single");

        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Round robin from pointer 0; requester 0 has two messages queued.
        set_word(0, 0, 8'h10, 32'h0000_0010, 1'b0);
        set_word(0, 1, 8'h14, 32'h0000_0014, 1'b0);
        set_word(1, 0, 8'h11, 32'h0000_0011, 1'b0);
        set_word(2, 0, 8'h12, 32'h0000_0012, 1'b0);
        set_word(3, 0, 8'h13, 32'h0000_0013, 1'b0);
        one_msg(0, 8'h10, 1'b0);
        one_msg(1, 8'h11, 1'b0);
        one_msg(2, 8'h12, 1'b0);
        one_msg(3, 8'h13, 1'b0);
        one_msg(0, 8'h14, 1'b0);
        for (int i = 0; i < N; i++) start_req(i, (i == 0) ? 2 : 1, 1'b0);
        wait_quiet("round_robin");

        // Priority tier: requester 2 first, then normal tier from pointer 3.
        for (int i = 0; i < N; i++)
            set_word(i, 0, AW'(8'h20 + i), DW'(32'h20 + i), 1'b0);
        one_msg(2, 8'h22, 1'b1);
        one_msg(3, 8'h23, 1'b0);
        one_msg(0, 8'h20, 1'b0);
        one_msg(1, 8'h21, 1'b0);
        for (int i = 0; i < N; i++) start_req(i, 1, (i == 2));
        wait_quiet("priority");
        rprio = '0;

        // Multi-word from requester 3 (pointer 2) while requester 0 waits.
        set_word(3, 0, 8'h30, 32'hA, 1'b1);
        set_word(3, 1, 8'h31, 32'hB, 1'b1);
        set_word(3, 2, 8'h32, 32'hC, 1'b0);
        set_word(0, 0, 8'h33, 32'h33, 1'b0);
        exp_word(8'h30, 32'hA, 1'b1, 1'b0); exp_ack(3);
        exp_word(8'h31, 32'hB, 1'b1, 1'b0); exp_ack(3);
        exp_word(8'h32, 32'hC, 1'b0, 1'b0); exp_ack(3);
        exp_done(3, 1'b1);
        one_msg(0, 8'h33, 1'b0);
        start_req(3, 3, 1'b0);
        start_req(0, 1, 1'b0);
        wait_quiet("multi_word");

        // Abort on word 2 of 3, then the requester retries from word 1.
        set_word(1, 0, 8'h40, 32'h40, 1'b1);
        set_word(1, 1, 8'h41, 32'h41, 1'b1);
        set_word(1, 2, 8'h42, 32'h42, 1'b0);
        fail_word = 2;
        exp_word(8'h40, 32'h40, 1'b1, 1'b0); exp_ack(1);
        exp_word(8'h41, 32'h41, 1'b1, 1'b0);
        exp_done(1, 1'b0);
        start_req(1, 3, 1'b0);
        wait_quiet("abort");
        fail_word = 0;
        exp_word(8'h40, 32'h40, 1'b1, 1'b0); exp_ack(1);
        exp_word(8'h41, 32'h41, 1'b1, 1'b0); exp_ack(1);
        exp_word(8'h42, 32'h42, 1'b0, 1'b0); exp_ack(1);
        exp_done(1, 1'b1);
        start_req(1, 3, 1'b0);
        wait_quiet("abort_retry");

        // Reset while waiting in RESP; pending requesters regranted from pointer 0.
        hold_resp = 1'b1;
        set_word(2, 0, 8'h50, 32'h50, 1'b0);
        set_word(1, 0, 8'h51, 32'h51, 1'b0);
        set_word(3, 0, 8'h53, 32'h53, 1'b0);
        exp_word(8'h50, 32'h50, 1'b0, 1'b0); exp_ack(2);
        start_req(1, 1, 1'b0);
        start_req(2, 1, 1'b0);
        start_req(3, 1, 1'b0);
        n = 0;
        while (!req_ack[2] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reset_test_ack_seen", 64'(n < 200), 64'h1);
        repeat (10) @(negedge clk);
        chk("busy_in_resp", 64'(busy), 64'h1);
        #1 rstn = 1'b0;
        #1 chk("midop_reset_outputs", out_bundle(), 64'h0);
        one_msg(1, 8'h51, 1'b0);
        one_msg(3, 8'h53, 1'b0);
        hold_resp = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        wait_quiet("after_reset");

        chk("words_left", 64'(exp_words.size()), 64'h0);
        chk("acks_left", 64'(exp_acks.size()), 64'h0);
        chk("dones_left", 64'(exp_dones.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ulpb_tx_sched.md
Name: ulpb_tx_sched

Overview:
- Shares the single TX port of the ULPB controller/node wrapper between NUM_REQ on-chip requesters in the CLK_EXT domain.
- Arbitrates with a two-tier scheme: PRIORITY requesters first, round-robin within each tier.
- Sequences the node's four-phase TX_REQ/TX_ACK word handshake and the TX_SUCC/TX_FAIL/TX_RESP_ACK response handshake.
- Locks the bus to one requester for a whole multi-word (TX_PEND) message and returns a per-requester completion status.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, `ADDR_WIDTH, TX address width.
- DATA_WIDTH, `DATA_WIDTH, TX data width.

Ports:
- CLK_EXT  in  1  system clock.
- RESETn  in  1  asynchronous active-low reset.
- REQ_VALID  in  NUM_REQ  requester i has a word ready; level, held until REQ_ACK[i].
- REQ_ADDR  in  NUM_REQ*ADDR_WIDTH  packed addresses, slice i.
- REQ_DATA  in  NUM_REQ*DATA_WIDTH  packed data, slice i.
- REQ_PEND  in  NUM_REQ  more words follow this one.
- REQ_PRIO  in  NUM_REQ  priority request; sampled only at grant.
- REQ_ACK  out  NUM_REQ  1-cycle pulse: word accepted by node.
- REQ_DONE  out  NUM_REQ  1-cycle pulse: message finished.
- REQ_STATUS  out  1  valid with REQ_DONE; 1=success, 0=fail.
- TX_ADDR  out  ADDR_WIDTH  to node.
- TX_DATA  out  DATA_WIDTH  to node.
- TX_PEND  out  1  to node.
- TX_REQ  out  1  to node.
- PRIORITY  out  1  to node.
- TX_ACK  in  1  from node; async.
- TX_SUCC  in  1  from node; async.
- TX_FAIL  in  1  from node; async.
- TX_RESP_ACK  out  1  to node.
- BUSY  out  1  FSM not IDLE.

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; rr pointer=0; grant register=0.
- TX_ACK, TX_SUCC, TX_FAIL pass through 2-flop synchronizers. All decisions use the synchronized versions; in-to-use latency is 2 cycles.
- TX_ADDR, TX_DATA, TX_PEND and PRIORITY are registered. They are loaded from the granted slice on entry to REQ and stay stable while TX_REQ=1.
- IDLE:
  - Candidate set = REQ_VALID & REQ_PRIO when that is nonzero, else REQ_VALID.
  - Pick the first candidate at or after the rr pointer, searching upward and wrapping.
  - If one exists: latch grant g, load TX_* from slice g, go to REQ. TX_REQ=1 the next cycle.
- REQ: hold TX_REQ=1 until sync TX_ACK=1. Then TX_REQ<=0, REQ_ACK[g] pulses 1 cycle, go to ACKLO.
- ACKLO: wait for sync TX_ACK=0.
  - If the word just sent had TX_PEND=1, go to NEXT.
  - Otherwise go to RESP.
- NEXT: word chaining stays locked to g.
  - When REQ_VALID[g]=1, load slice g and go to REQ.
  - If REQ_VALID[g] is dropped mid-message, TX_PEND stays 1 and the block waits; this is a requester protocol violation.
- RESP: wait for sync TX_SUCC or TX_FAIL. Then assert TX_RESP_ACK=1, REQ_DONE[g]=1 for 1 cycle, REQ_STATUS=TX_SUCC, and go to RACK.
- RACK: hold TX_RESP_ACK=1 until TX_SUCC=0 and TX_FAIL=0. Then TX_RESP_ACK<=0, rr pointer<=g+1 mod NUM_REQ, go to IDLE.
- Abort: sync TX_FAIL=1 in REQ, ACKLO or NEXT means arbitration was lost or the node aborted.
  - Drop TX_REQ.
  - REQ_DONE[g] pulses with REQ_STATUS=0; no REQ_ACK is issued for the pending word.
  - Go to RACK. The requester re-requests from the first word.
- Simultaneous TX_ACK and TX_FAIL in REQ: FAIL wins; no REQ_ACK.
- Requests arriving outside IDLE are ignored until the return to IDLE. A non-granted requester's VALID is never acknowledged.
- The rr pointer advances only after a completed or failed message, never on grant. This guarantees fairness within a tier.
- A PRIORITY tier can starve the normal tier; this is accepted by design.
- Reset mid-operation: everything returns to reset values immediately. TX_REQ=0 and TX_RESP_ACK=0 asynchronously. The node recovers through its own RESETn.

Decomposition:
- Shared include (ulpb_def.v): ADDR_WIDTH and DATA_WIDTH defines, plus FSM state encodings IDLE, REQ, ACKLO, NEXT, RESP, RACK as localparam/`define.
- One sub-module, ulpb_rr_pick:
  - Combinational.
  - Inputs: NUM_REQ request vector and the pointer.
  - Outputs: one-hot grant and a found flag.
  - Instantiated once on the tier-selected candidate vector.
- The synchronizers are inline.

Test Plan:
- Single word: REQ_VALID=4'b0010, ADDR=8'h05, PEND=0; node ACKs then SUCC -> TX_ADDR=8'h05, one REQ_ACK[1], REQ_DONE[1] with STATUS=1, TX_RESP_ACK released after SUCC falls, pointer=2.
- Round-robin: all four valid with PRIO=0, each completes -> grant order 0,1,2,3,0. No requester is granted twice before the others are served.
- Priority: VALID=4'b1111, PRIO=4'b0100, pointer=0 -> requester 2 granted first; PRIORITY=1 on the bus.
- Multi-word: requester 3 sends words 32'hA, 32'hB (PEND=1), 32'hC (PEND=0) while requester 0 is valid -> three REQ_ACK[3] pulses, TX_PEND=1,1,0, requester 0 not granted until RACK completes.
- Abort: TX_FAIL raised while TX_REQ=1 on word 2 of 3 -> TX_REQ drops, no REQ_ACK, REQ_DONE with STATUS=0, TX_RESP_ACK handshake completes, return to IDLE.
- Reset: RESETn low during RESP -> all outputs 0 the same cycle; after release, a pending VALID is re-granted from IDLE.
